// File: rtl/data_memory_responder_pkg.sv
// Shared data-memory types: access sizes, fault causes, responder states
// and the default geometry of the CPU data segment.
package data_memory_responder_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] data_addr_t;

  // Default RAM geometry: 128 words starting at the data segment base.
  localparam int unsigned DATA_CAPACITY        = 128;
  localparam data_addr_t  DATA_OFFSET          = 32'h1001_0000;
  localparam int unsigned DATA_MEM_WAIT_STATES = 1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_BAD  = 2'd3
  } access_size_e;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_RANGE      = 2'd2,
    FAULT_SIZE       = 2'd3
  } fault_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } data_mem_state_e;

  // True when a legal-size access at this address is not naturally aligned.
  function automatic logic is_misaligned(access_size_e size, logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_HALF: mis = lane[0];
      SIZE_WORD: mis = (lane != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_memory_responder_lane_align.sv
// Little-endian byte-lane steering between the CPU's right-justified data
// and a 32-bit RAM word: store byte enables / replicated write data, and
// load lane selection with sign or zero extension.
module data_memory_responder_lane_align
  import data_memory_responder_pkg::*;
(
  input  access_size_e size_i,
  input  logic [1:0]   lane_i,
  input  logic         signed_i,
  input  data_t        wdata_i,
  input  data_t        rword_i,
  output logic [3:0]   byte_en_o,
  output data_t        wword_o,
  output data_t        rdata_ext_o
);

  logic [15:0] lane_half;

  // Bring the addressed lane(s) down to bit 0 before extension.
  assign lane_half = 16'(rword_i >> {lane_i, 3'b000});

  // Steer lanes according to size; illegal size never reaches the RAM.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    byte_en_o   = 4'b0000;
    wword_o     = '0;
    rdata_ext_o = '0;
    case (size_i)
      SIZE_BYTE: begin
        byte_en_o   = 4'b0001 << lane_i;
        wword_o     = {4{wdata_i[7:0]}};
        rdata_ext_o = {{24{signed_i & lane_half[7]}}, lane_half[7:0]};
      end
      SIZE_HALF: begin
        byte_en_o   = 4'b0011 << lane_i;
        wword_o     = {2{wdata_i[15:0]}};
        rdata_ext_o = {{16{signed_i & lane_half[15]}}, lane_half};
      end
      SIZE_WORD: begin
        byte_en_o   = 4'b1111;
        wword_o     = wdata_i;
        rdata_ext_o = rword_i;
      end
      default: begin
        byte_en_o   = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for CPU data loads and stores. One request at a
// time: checks size/range/alignment at accept, waits WaitStates cycles,
// performs the word-RAM operation and holds the response until taken.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned WaitStates  = DATA_MEM_WAIT_STATES,
  parameter int unsigned Capacity    = DATA_CAPACITY,
  parameter data_addr_t  BaseAddress = DATA_OFFSET
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  resp_fault_cause,
  output logic [31:0] resp_fault_addr
);

  localparam int unsigned IdxW       = (Capacity > 1) ? $clog2(Capacity) : 1;
  localparam data_addr_t  RangeBytes = data_addr_t'(Capacity) << 2;

  // Control state and latched request.
  data_mem_state_e state_q;
  logic [3:0]      cnt_q;
  logic            write_q;
  access_size_e    size_q;
  logic            signed_q;
  logic [1:0]      lane_q;
  logic [IdxW-1:0] idx_q;
  data_t           wdata_q;

  // Registered response.
  logic            resp_valid_q;
  data_t           rdata_q;
  logic            fault_q;
  fault_cause_e    cause_q;
  data_addr_t      fault_addr_q;

  // Accept-time decode of the incoming request.
  access_size_e    size_d;
  data_addr_t      req_off;
  fault_cause_e    cause_d;
  logic [IdxW-1:0] idx_d;

  // RAM and lane steering.
  data_t           mem_q [Capacity];
  data_t           rword;
  logic [3:0]      byte_en;
  data_t           wword;
  data_t           rdata_ext;
  logic            ram_op;
  logic            ram_we;

  assign req_ready = (state_q == ST_IDLE) && !reset;

  // Classify the presented request; offset wraps, so low addresses land out of range.
  always_comb begin
    size_d  = access_size_e'(req_size);
    req_off = req_addr - BaseAddress;
    idx_d   = req_off[IdxW+1:2];
    cause_d = FAULT_NONE;
    if (size_d == SIZE_BAD) begin
      cause_d = FAULT_SIZE;
    end else if (req_off >= RangeBytes) begin
      cause_d = FAULT_RANGE;
    end else if (is_misaligned(size_d, req_addr[1:0])) begin
      cause_d = FAULT_MISALIGNED;
    end
  end

  assign rword  = mem_q[idx_q];
  assign ram_op = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  // A reset on the commit edge must suppress the write.
  assign ram_we = ram_op && write_q && !reset;

  data_memory_responder_lane_align u_lane_align (
    .size_i      (size_q),
    .lane_i      (lane_q),
    .signed_i    (signed_q),
    .wdata_i     (wdata_q),
    .rword_i     (rword),
    .byte_en_o   (byte_en),
    .wword_o     (wword),
    .rdata_ext_o (rdata_ext)
  );

  // Request/response FSM with wait counter and registered response outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      size_q       <= SIZE_BYTE;
      signed_q     <= 1'b0;
      lane_q       <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      fault_q      <= 1'b0;
      cause_q      <= FAULT_NONE;
      fault_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Reset is low here, so req_ready equals being in IDLE.
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= size_d;
            signed_q <= req_signed;
            lane_q   <= req_addr[1:0];
            idx_q    <= idx_d;
            wdata_q  <= req_wdata;
            cause_q  <= cause_d;
            if (cause_d != FAULT_NONE) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              fault_q      <= 1'b1;
              rdata_q      <= '0;
              fault_addr_q <= req_addr;
            end else begin
              state_q      <= ST_ACCESS;
              cnt_q        <= 4'(WaitStates);
              fault_q      <= 1'b0;
              fault_addr_q <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= write_q ? '0 : rdata_ext;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Byte-enabled RAM write on the final ACCESS edge of a legal store.
  // NOTE: the RAM array is deliberately not reset; only control state is, so contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_q[idx_q][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end

  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = rdata_q;
  assign resp_fault       = fault_q;
  assign resp_fault_cause = cause_q;
  assign resp_fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised scoreboard bench for data_memory_responder: a byte-array
// reference model predicts every response; a monitor checks them.
module tb_data_memory_responder;

  localparam int          WS   = 1;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main DUT (WaitStates=1)
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata, resp_fault_addr;
  logic [1:0]  resp_fault_cause;

  // Zero-wait-state DUT
  logic        req_valid0, req_ready0, req_write0, req_signed0;
  logic [1:0]  req_size0;
  logic [31:0] req_addr0, req_wdata0;
  logic        resp_valid0, resp_ready0, resp_fault0;
  logic [31:0] resp_rdata0, resp_fault_addr0;
  logic [1:0]  resp_fault_cause0;

  data_memory_responder #(.WaitStates(WS)) dut (
    .clock(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_fault_cause(resp_fault_cause), .resp_fault_addr(resp_fault_addr)
  );

  data_memory_responder #(.WaitStates(0)) dut0 (
    .clock(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_size(req_size0), .req_signed(req_signed0), .req_addr(req_addr0),
    .req_wdata(req_wdata0), .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_fault(resp_fault0),
    .resp_fault_cause(resp_fault_cause0), .resp_fault_addr(resp_fault_addr0)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: flat little-endian byte array of the data segment
  logic [7:0] mem8 [512];

  function automatic logic [1:0] model_cause(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 2'd3;
    if ((a - BASE) >= 32'd512) return 2'd2;
    if ((a % (32'd1 << sz)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int unsigned off, nb;
    logic [31:0] v;
    off = a - BASE;
    nb  = 1 << sz;
    v   = 0;
    for (int i = 0; i < int'(nb); i++) v = v + (32'(mem8[off + i]) << (8 * i));
    if (sg && nb < 4 && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  function automatic void model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned off, nb;
    off = a - BASE;
    nb  = 1 << sz;
    for (int i = 0; i < int'(nb); i++) mem8[off + i] = 8'(wd >> (8 * i));
  endfunction

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  cause;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q [$];

  // Issue one request on the main DUT; returns at the negedge after accept.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    e.write = w; e.size = sz; e.addr = a; e.wdata = wd;
    e.cause = model_cause(sz, a);
    e.rdata = (w || e.cause != 0) ? 32'd0 : model_load(sz, sg, a);
    e.acc   = cyc + 1;
    e.lat   = (e.cause != 0) ? 1 : WS + 2;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Response monitor: pops the scoreboard on each new response, then checks hold stability.
  logic        seen = 1'b0;
  logic [66:0] snap;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      seen = 1'b0;
    end else if (resp_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_fault", 32'(resp_fault), 32'(e.cause != 0));
          check("resp_cause", 32'(resp_fault_cause), 32'(e.cause));
          if (e.cause != 0) check("resp_fault_addr", resp_fault_addr, e.addr);
          check("resp_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
          if (e.write && e.cause == 0) model_store(e.size, e.addr, e.wdata);
        end
        seen = 1'b1;
        snap = {resp_rdata, resp_fault, resp_fault_cause, resp_fault_addr};
      end else begin
        total++;
        if ({resp_rdata, resp_fault, resp_fault_cause, resp_fault_addr} !== snap) begin
          bad++;
          $display("FAIL resp_hold: got %h expected %h",
                   {resp_rdata, resp_fault, resp_fault_cause, resp_fault_addr}, snap);
        end
      end
      check("req_ready_in_resp", 32'(req_ready), 32'd0);
      if (resp_ready) seen = 1'b0;
    end
  end

  // Randomised back-pressure, changed just after the edge so it is stable at negedge.
  logic rr_random = 1'b0;
  always @(posedge clk) begin
    if (rr_random) begin
      #1 resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int unsigned sel;
    int          n, a1, a2;
    logic [31:0] wd;

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_size0 = 2'd0; req_signed0 = 1'b0;
    req_addr0 = '0; req_wdata0 = '0; resp_ready0 = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_fault", 32'(resp_fault), 32'd0);
    check("rst_cause", 32'(resp_fault_cause), 32'd0);
    check("rst_fault_addr", resp_fault_addr, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_req_ready0", 32'(req_ready0), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    rr_random = 1'b1;

    // Word store/load round trip
    issue(1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0);

    // Sub-word loads with extension, byte store into the middle lane
    issue(1'b0, 2'd0, 1'b1, 32'h1001_0007, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h1001_0007, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h1001_0004, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h1001_0005, 32'hAAAA_AA12);
    issue(1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0);
    drain();

    // Initialise the rest of the working window and the last word
    for (int w = 0; w < 16; w++) begin
      if (w != 1) issue(1'b1, 2'd2, 1'b0, BASE + 32'(4 * w), $urandom);
    end
    issue(1'b1, 2'd2, 1'b0, BASE + 32'h1FC, $urandom);

    // Faults: misaligned, out of range (both ends), bad size; RAM untouched
    issue(1'b0, 2'd2, 1'b0, 32'h1001_0002, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h1001_0200, 32'h1111_1111);
    issue(1'b1, 2'd3, 1'b0, 32'h1001_0008, 32'h2222_2222);
    issue(1'b1, 2'd1, 1'b0, 32'h1001_0009, 32'h3333_3333);
    issue(1'b0, 2'd0, 1'b0, 32'h1000_FFFF, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h1001_01FC, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0);
    drain();

    // Back-pressure: response held, req ignored while stalled
    rr_random = 1'b0;
    @(posedge clk); #1 resp_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h1001_000C, 32'h0);
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check("stall_resp_seen", 32'(resp_valid), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h1001_000C;
    req_wdata = 32'hBADB_ADBA;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(resp_valid), 32'd1);
    end
    req_valid = 1'b0;
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_valid", 32'(resp_valid), 32'd0);
    check("release_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h1001_000C, 32'h0);
    drain();
    rr_random = 1'b1;

    // Reset while a store sits in ACCESS: store must not commit
    issue(1'b1, 2'd0, 1'b0, 32'h1001_0010, 32'h0000_0055);
    reset = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_valid", 32'(resp_valid), 32'd0);
      check("rst_mid_ready", 32'(req_ready), 32'd0);
    end
    reset = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'h0);
    drain();

    // Randomised mix
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = BASE + 32'($urandom_range(0, 63));
      else if (sel == 7) a = BASE + 32'h1FC + 32'($urandom_range(0, 3));
      else if (sel == 8) a = BASE + 32'h200 + 32'($urandom_range(0, 7));
      else               a = BASE - 32'($urandom_range(1, 8));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(($urandom_range(0, 2) == 0), sz, 1'($urandom), a, $urandom);
    end
    drain();

    // Zero wait states: back-to-back sw/lw with 3-cycle spacing
    for (int k = 0; k < 3; k++) begin
      wd = $urandom;
      @(negedge clk);
      req_valid0 = 1'b1; req_write0 = 1'b1; req_size0 = 2'd2;
      req_addr0 = BASE + 32'h20 + 32'(4 * k); req_wdata0 = wd;
      n = 0;
      while (!req_ready0 && n < 20) begin @(negedge clk); n++; end
      a1 = cyc + 1;
      @(negedge clk);
      req_write0 = 1'b0;
      n = 0;
      while (!req_ready0 && n < 20) begin @(negedge clk); n++; end
      a2 = cyc + 1;
      check("ws0_spacing", 32'(a2 - a1), 32'd3);
      @(negedge clk);
      req_valid0 = 1'b0;
      n = 0;
      while (!resp_valid0 && n < 20) begin @(negedge clk); n++; end
      check("ws0_latency", 32'(cyc + 1 - a2), 32'd2);
      check("ws0_rdata", resp_rdata0, wd);
      check("ws0_fault", 32'(resp_fault0), 32'd0);
      repeat (2) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
